ctrl_pipe: RTL and testbench

- Consumer end of the decoded control bundle produced in ID.
- Carries the control fields and register indices through the EX, MEM and WB pipeline registers.
- Detects load-use hazards and inserts bubbles; kills wrong-path instructions on jump or taken branch.
- Generates EX-stage forwarding selects and keeps saturating stall/flush event counters.

---
 rtl/ctrl_pipe_if.sv | 75 +++++++
 rtl/ctrl_pipe.sv | 174 +++++++++++++++++
 tb/tb_ctrl_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: decoded ID bundle in; EX/MEM/WB stage control, forwarding selects,
// hazard strobes and event counters out.
interface ctrl_pipe_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_mem_rd;
  logic             id_mem_wr;
  logic             id_reg_wr;
  logic             id_mux_reg_wr;
  logic             id_jump;
  logic             id_branch;
  logic             id_jalr;
  logic [1:0]       id_ula_op;
  logic [1:0]       id_alu_src1;
  logic [1:0]       id_alu_src2;
  logic [4:0]       id_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             branch_taken;

  logic             ex_valid;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic             ex_reg_wr;
  logic             ex_mux_reg_wr;
  logic             ex_jump;
  logic             ex_branch;
  logic             ex_jalr;
  logic [1:0]       ex_ula_op;
  logic [1:0]       ex_alu_src1;
  logic [1:0]       ex_alu_src2;
  logic [4:0]       ex_rd;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;

  logic             mem_valid;
  logic             mem_mem_rd;
  logic             mem_mem_wr;
  logic             mem_reg_wr;
  logic             mem_mux_reg_wr;
  logic [4:0]       mem_rd;

  logic             wb_valid;
  logic             wb_reg_wr;
  logic             wb_mux_reg_wr;
  logic [4:0]       wb_rd;

  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_valid, id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_jump, id_branch,
           id_jalr, id_ula_op, id_alu_src1, id_alu_src2, id_rd, id_rs1, id_rs2, branch_taken,
    output ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump, ex_branch,
           ex_jalr, ex_ula_op, ex_alu_src1, ex_alu_src2, ex_rd, ex_rs1, ex_rs2,
           mem_valid, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_mux_reg_wr, mem_rd,
           wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd,
           fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_jump, id_branch,
           id_jalr, id_ula_op, id_alu_src1, id_alu_src2, id_rd, id_rs1, id_rs2, branch_taken,
    input  ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump, ex_branch,
           ex_jalr, ex_ula_op, ex_alu_src1, ex_alu_src2, ex_rd, ex_rs1, ex_rs2,
           mem_valid, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_mux_reg_wr, mem_rd,
           wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd,
           fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Carries decoded control through EX/MEM/WB; load-use stall, redirect flush, EX forwarding.
// ID->EX 1 cycle, MEM 2, WB 3; MEM/WB never back-pressure, stall/flush bubble EX.
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mux_reg_wr;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic [1:0] ula_op;
    logic [1:0] alu_src1;
    logic [1:0] alu_src2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_t;

  typedef struct packed {
    logic       valid;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mux_reg_wr;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       valid;
    logic       reg_wr;
    logic       mux_reg_wr;
    logic [4:0] rd;
  } wb_t;

  ex_t              r_ex;
  ex_t              w_ex_nxt;
  mem_t             r_mem;
  wb_t              r_wb;
  logic             w_id_reg_wr;
  logic             w_redirect;
  logic             w_load_use;
  logic             w_stall;
  logic             w_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input mem_t m, input wb_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.valid && m.reg_wr && (m.rd != 5'd0) && (m.rd == rs))
      sel = 2'b01;
    else if (w.valid && w.reg_wr && (w.rd != 5'd0) && (w.rd == rs))
      sel = 2'b10;
    return sel;
  endfunction

  // Stores and branches never write rd; a non-writing rd is zeroed so it cannot match later.
  assign w_id_reg_wr = bus.id_reg_wr & ~bus.id_branch & ~bus.id_mem_wr;

  assign w_redirect = r_ex.valid & (r_ex.jump | (r_ex.branch & bus.branch_taken));
  assign w_load_use = r_ex.valid & r_ex.mem_rd & (r_ex.rd != 5'd0) & bus.id_valid &
                      ((r_ex.rd == bus.id_rs1) | (r_ex.rd == bus.id_rs2));

  assign w_flush = w_redirect;
  assign w_stall = w_load_use & ~w_redirect;

  always_comb begin
    w_ex_nxt = '0;
    if (!w_flush && !w_stall) begin
      w_ex_nxt.valid      = bus.id_valid;
      w_ex_nxt.mem_rd     = bus.id_mem_rd;
      w_ex_nxt.mem_wr     = bus.id_mem_wr;
      w_ex_nxt.reg_wr     = w_id_reg_wr;
      w_ex_nxt.mux_reg_wr = bus.id_mux_reg_wr;
      w_ex_nxt.jump       = bus.id_jump;
      w_ex_nxt.branch     = bus.id_branch;
      w_ex_nxt.jalr       = bus.id_jalr;
      w_ex_nxt.ula_op     = bus.id_ula_op;
      w_ex_nxt.alu_src1   = bus.id_alu_src1;
      w_ex_nxt.alu_src2   = bus.id_alu_src2;
      w_ex_nxt.rd         = w_id_reg_wr ? bus.id_rd : 5'd0;
      w_ex_nxt.rs1        = bus.id_rs1;
      w_ex_nxt.rs2        = bus.id_rs2;
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_ex.valid) begin
      w_fwd_a = fwd_sel(r_ex.rs1, r_mem, r_wb);
      w_fwd_b = fwd_sel(r_ex.rs2, r_mem, r_wb);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex             <= w_ex_nxt;
      r_mem.valid      <= r_ex.valid;
      r_mem.mem_rd     <= r_ex.mem_rd;
      r_mem.mem_wr     <= r_ex.mem_wr;
      r_mem.reg_wr     <= r_ex.reg_wr;
      r_mem.mux_reg_wr <= r_ex.mux_reg_wr;
      r_mem.rd         <= r_ex.rd;
      r_wb.valid       <= r_mem.valid;
      r_wb.reg_wr      <= r_mem.reg_wr;
      r_wb.mux_reg_wr  <= r_mem.mux_reg_wr;
      r_wb.rd          <= r_mem.rd;
    end
  end

  // Event counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.ex_valid       = r_ex.valid;
  assign bus.ex_mem_rd      = r_ex.mem_rd;
  assign bus.ex_mem_wr      = r_ex.mem_wr;
  assign bus.ex_reg_wr      = r_ex.reg_wr;
  assign bus.ex_mux_reg_wr  = r_ex.mux_reg_wr;
  assign bus.ex_jump        = r_ex.jump;
  assign bus.ex_branch      = r_ex.branch;
  assign bus.ex_jalr        = r_ex.jalr;
  assign bus.ex_ula_op      = r_ex.ula_op;
  assign bus.ex_alu_src1    = r_ex.alu_src1;
  assign bus.ex_alu_src2    = r_ex.alu_src2;
  assign bus.ex_rd          = r_ex.rd;
  assign bus.ex_rs1         = r_ex.rs1;
  assign bus.ex_rs2         = r_ex.rs2;

  assign bus.mem_valid      = r_mem.valid;
  assign bus.mem_mem_rd     = r_mem.mem_rd;
  assign bus.mem_mem_wr     = r_mem.mem_wr;
  assign bus.mem_reg_wr     = r_mem.reg_wr;
  assign bus.mem_mux_reg_wr = r_mem.mux_reg_wr;
  assign bus.mem_rd         = r_mem.rd;

  assign bus.wb_valid       = r_wb.valid;
  assign bus.wb_reg_wr      = r_wb.reg_wr;
  assign bus.wb_mux_reg_wr  = r_wb.mux_reg_wr;
  assign bus.wb_rd          = r_wb.rd;

  assign bus.fwd_a          = w_fwd_a;
  assign bus.fwd_b          = w_fwd_b;
  assign bus.stall          = w_stall;
  assign bus.flush          = w_flush;
  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and random stimulus for ctrl_pipe, checked each cycle against a pipeline model.
module tb_ctrl_pipe;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic       v, mem_rd, mem_wr, reg_wr, mux, jump, branch, jalr;
    logic [1:0] ula, s1, s2;
    logic [4:0] rd, rs1, rs2;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.CNT_W(CW)) bus ();
  ctrl_pipe #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   checks = 0;
  int   failures = 0;
  ins_t cur, m_ex, m_mem, m_wb, zero_i;
  logic cur_bt = 1'b0;
  int   m_scnt = 0;
  int   m_fcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic v, mem_rd, mem_wr, reg_wr, mux, jump, branch,
                              input logic [4:0] rd, rs1, rs2);
    ins_t i;
    i = '{default: '0};
    i.v = v; i.mem_rd = mem_rd; i.mem_wr = mem_wr; i.reg_wr = reg_wr; i.mux = mux;
    i.jump = jump; i.branch = branch; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic ins_t LW(input logic [4:0] rd, rs1);
    return mk(1, 1, 0, 1, 1, 0, 0, rd, rs1, 5'd0);
  endfunction
  function automatic ins_t ALU(input logic [4:0] rd, rs1, rs2);
    return mk(1, 0, 0, 1, 0, 0, 0, rd, rs1, rs2);
  endfunction
  function automatic ins_t NOP();
    return mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.v      = ($urandom_range(0, 9) != 0);
    i.mem_rd = ($urandom_range(0, 2) == 0);
    i.mem_wr = ($urandom_range(0, 4) == 0);
    i.reg_wr = ($urandom_range(0, 3) != 0);
    i.mux    = 1'($urandom);
    i.jump   = ($urandom_range(0, 9) == 0);
    i.branch = ($urandom_range(0, 5) == 0);
    i.jalr   = 1'($urandom);
    i.ula    = 2'($urandom);
    i.s1     = 2'($urandom);
    i.s2     = 2'($urandom);
    i.rd     = 5'($urandom_range(0, 3));
    i.rs1    = 5'($urandom_range(0, 3));
    i.rs2    = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // Model: what each stage should hold, derived from the pipeline rules.
  function automatic logic m_redirect();
    return m_ex.v && (m_ex.jump || (m_ex.branch && cur_bt));
  endfunction
  function automatic logic m_load_use();
    return m_ex.v && m_ex.mem_rd && (m_ex.rd != 0) && cur.v &&
           ((m_ex.rd == cur.rs1) || (m_ex.rd == cur.rs2));
  endfunction
  function automatic logic m_stall();
    return !m_redirect() && m_load_use();
  endfunction
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (!m_ex.v) return 2'd0;
    if (m_mem.v && m_mem.reg_wr && m_mem.rd != 0 && m_mem.rd == rs) return 2'd1;
    if (m_wb.v && m_wb.reg_wr && m_wb.rd != 0 && m_wb.rd == rs) return 2'd2;
    return 2'd0;
  endfunction
  function automatic ins_t sanit(input ins_t i);
    ins_t o;
    o = i;
    o.reg_wr = i.reg_wr && !i.branch && !i.mem_wr;
    if (!o.reg_wr) o.rd = 5'd0;
    return o;
  endfunction

  task automatic m_reset();
    m_ex = zero_i; m_mem = zero_i; m_wb = zero_i;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic apply();
    bus.id_valid = cur.v;       bus.id_mem_rd = cur.mem_rd;   bus.id_mem_wr = cur.mem_wr;
    bus.id_reg_wr = cur.reg_wr; bus.id_mux_reg_wr = cur.mux;  bus.id_jump = cur.jump;
    bus.id_branch = cur.branch; bus.id_jalr = cur.jalr;       bus.id_ula_op = cur.ula;
    bus.id_alu_src1 = cur.s1;   bus.id_alu_src2 = cur.s2;     bus.id_rd = cur.rd;
    bus.id_rs1 = cur.rs1;       bus.id_rs2 = cur.rs2;         bus.branch_taken = cur_bt;
  endtask

  task automatic look();
    apply();
    #1;
    chk("ex", 32'({bus.ex_valid, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_reg_wr, bus.ex_mux_reg_wr,
                   bus.ex_jump, bus.ex_branch, bus.ex_jalr, bus.ex_ula_op, bus.ex_alu_src1,
                   bus.ex_alu_src2, bus.ex_rd, bus.ex_rs1, bus.ex_rs2}),
              32'({m_ex.v, m_ex.mem_rd, m_ex.mem_wr, m_ex.reg_wr, m_ex.mux, m_ex.jump,
                   m_ex.branch, m_ex.jalr, m_ex.ula, m_ex.s1, m_ex.s2, m_ex.rd, m_ex.rs1, m_ex.rs2}));
    chk("mem", 32'({bus.mem_valid, bus.mem_mem_rd, bus.mem_mem_wr, bus.mem_reg_wr,
                    bus.mem_mux_reg_wr, bus.mem_rd}),
               32'({m_mem.v, m_mem.mem_rd, m_mem.mem_wr, m_mem.reg_wr, m_mem.mux, m_mem.rd}));
    chk("wb", 32'({bus.wb_valid, bus.wb_reg_wr, bus.wb_mux_reg_wr, bus.wb_rd}),
              32'({m_wb.v, m_wb.reg_wr, m_wb.mux, m_wb.rd}));
    chk("stall", 32'(bus.stall), 32'(m_stall()));
    chk("flush", 32'(bus.flush), 32'(m_redirect()));
    chk("fwd_a", 32'(bus.fwd_a), 32'(m_fwd(m_ex.rs1)));
    chk("fwd_b", 32'(bus.fwd_b), 32'(m_fwd(m_ex.rs2)));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fcnt));
  endtask

  task automatic tick();
    logic redir, st;
    redir = m_redirect();
    st    = m_stall();
    @(posedge clk);
    if (st && m_scnt < MAXC) m_scnt++;
    if (redir && m_fcnt < MAXC) m_fcnt++;
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = (redir || st) ? zero_i : sanit(cur);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    look();
    chk("rst_valids", 32'({bus.ex_valid, bus.mem_valid, bus.wb_valid}), 32'd0);
    chk("rst_cnts", 32'({bus.stall_cnt, bus.flush_cnt}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    zero_i = '{default: '0};
    cur = NOP();
    m_reset();
    apply();
    @(negedge clk);
    look();
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5 ; add x6,x5,x1 -> one stall, then WB forwarding
    cur = LW(5, 1);     look(); tick();
    cur = ALU(6, 5, 1); look(); chk("lu_stall", 32'(bus.stall), 32'd1); tick();
    look(); chk("lu_release", 32'(bus.stall), 32'd0); tick();
    cur = NOP();        look();
    chk("lu_ex_rd", 32'(bus.ex_rd), 32'd6);
    chk("lu_fwd_a", 32'(bus.fwd_a), 32'd2);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    tick();

    // add x3 ; sub x4,x3,x3 -> MEM forwarding on both operands
    cur = ALU(3, 1, 2); look(); tick();
    cur = ALU(4, 3, 3); look(); chk("raw_stall", 32'(bus.stall), 32'd0); tick();
    cur = NOP();        look();
    chk("raw_fwd", 32'({bus.fwd_a, bus.fwd_b}), 32'({2'd1, 2'd1}));
    tick();

    // taken beq flushes
    cur = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 2); look(); tick();
    cur = ALU(6, 5, 1); cur_bt = 1'b1; look();
    chk("br_flush", 32'({bus.flush, bus.stall}), 32'({1'b1, 1'b0}));
    tick();
    cur_bt = 1'b0; cur = NOP(); look();
    chk("br_bubble", 32'(bus.ex_valid), 32'd0);
    chk("br_fcnt", 32'(bus.flush_cnt), 32'd1);
    tick();

    // jump that is also a load: redirect beats load-use
    cur = mk(1, 1, 0, 1, 0, 1, 0, 5, 0, 0); look(); tick();
    cur = ALU(6, 5, 1); look();
    chk("jmp_prio", 32'({bus.flush, bus.stall}), 32'({1'b1, 1'b0}));
    tick();
    cur = NOP(); look(); chk("jmp_bubble", 32'(bus.ex_valid), 32'd0); tick();

    // not-taken beq with reg_wr set in ID: flows, never writes
    cur = mk(1, 0, 0, 1, 0, 0, 1, 9, 1, 2); look(); tick();
    cur = ALU(9, 1, 2); look(); chk("nt_flush", 32'(bus.flush), 32'd0); tick();
    cur = NOP(); look();
    chk("nt_ex", 32'({bus.ex_valid, bus.ex_rd}), 32'({1'b1, 5'd9}));
    chk("nt_mem", 32'({bus.mem_valid, bus.mem_reg_wr}), 32'({1'b1, 1'b0}));
    tick();

    // sw with rd=7 -> rd zeroed, no forwarding for x7
    cur = mk(1, 0, 1, 0, 0, 0, 0, 7, 1, 2); look(); tick();
    cur = ALU(8, 7, 0); look();
    chk("sw_ex", 32'({bus.ex_reg_wr, bus.ex_rd}), 32'd0);
    tick();
    cur = NOP(); look(); chk("sw_fwd", 32'(bus.fwd_a), 32'd0); tick();

    // three in flight, then async reset
    for (int i = 1; i <= 3; i++) begin
      cur = ALU(5'(i), 5'(i), 5'(i)); look(); tick();
    end
    do_reset();

    // lw x5,(x5) repeatedly stalls every other cycle; drive past saturation
    cur = LW(5, 5);
    for (int i = 0; i < 2 * (MAXC + 1 + 3) + 2; i++) begin
      look(); tick();
    end
    look();
    chk("sat_stall", 32'(bus.stall_cnt), 32'(MAXC));
    do_reset();

    // random traffic; ID is held while a stall is expected
    for (int i = 0; i < 400; i++) begin
      cur_bt = 1'($urandom);
      apply();
      if (!m_stall()) cur = rnd_ins();
      look(); tick();
    end
    look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
